// File: rtl/i2c_slave_target.sv
// I2C target answering one 7-bit address: written bytes leave on rx_*, read bytes come from tx_*.
// Optional: define I2C_SLAVE_CLK_STRETCH_EN to hold SCL low while read data is unavailable.
module i2c_slave_target #(
    parameter int                        I2C_ADDR_WIDTH    = 7,
    parameter int                        I2C_DATA_WIDTH    = 8,
    parameter logic [I2C_ADDR_WIDTH-1:0] I2C_SLAVE_ADDRESS = 7'h22
) (
    input  logic                      clk_i,
    input  logic                      rst_n_i,
    input  logic                      scl_i,
    input  logic                      sda_i,
    output logic                      scl_oe_o,
    output logic                      sda_oe_o,
    output logic [I2C_DATA_WIDTH-1:0] rx_data_o,
    output logic                      rx_valid_o,
    input  logic                      rx_ready_i,
    input  logic [I2C_DATA_WIDTH-1:0] tx_data_i,
    input  logic                      tx_valid_i,
    output logic                      tx_ready_o,
    output logic                      start_o,
    output logic                      stop_o,
    output logic                      op_o,
    output logic                      busy_o
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_WR_DATA,
        ST_WR_ACK,
        ST_RD_DATA,
        ST_RD_ACK,
        ST_WAIT_STOP
    } state_e;

    localparam logic [3:0] LAST_BIT = 4'(I2C_DATA_WIDTH - 1);
    localparam logic [3:0] NUM_BITS = 4'(I2C_DATA_WIDTH);

    logic scl_s1_q, scl_s2_q, scl_h_q;
    logic sda_s1_q, sda_s2_q, sda_h_q;

    state_e                    state_q, state_d;
    logic [3:0]                cnt_q, cnt_d;
    logic [I2C_DATA_WIDTH-1:0] shift_q, shift_d;
    logic [I2C_DATA_WIDTH-1:0] tx_shift_q, tx_shift_d;
    logic [I2C_DATA_WIDTH-1:0] rx_data_q, rx_data_d;
    logic                      rx_valid_q, rx_valid_d;
    logic                      tx_ready_q, tx_ready_d;
    logic                      start_q, start_d;
    logic                      stop_q, stop_d;
    logic                      op_q, op_d;
    logic                      busy_q, busy_d;
    logic                      sda_oe_q, sda_oe_d;
`ifdef I2C_SLAVE_CLK_STRETCH_EN
    logic                      stretch_q, stretch_d;
    logic                      scl_oe_q, scl_oe_d;
`endif

    logic                      scl_rise, scl_fall, start_det, stop_det, load_tx;
    logic [I2C_DATA_WIDTH-1:0] shift_in;

    assign scl_rise  = scl_s2_q & ~scl_h_q;
    assign scl_fall  = ~scl_s2_q & scl_h_q;
    assign start_det = scl_s2_q & sda_h_q & ~sda_s2_q;
    assign stop_det  = scl_s2_q & ~sda_h_q & sda_s2_q;
    assign shift_in  = {shift_q[I2C_DATA_WIDTH-2:0], sda_s2_q};

    always_comb begin
        // NOTE: every _d takes its hold value first, so no path through the case infers a latch.
        state_d    = state_q;
        cnt_d      = cnt_q;
        shift_d    = shift_q;
        tx_shift_d = tx_shift_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = rx_valid_q & ~rx_ready_i;
        tx_ready_d = 1'b0;
        start_d    = 1'b0;
        stop_d     = 1'b0;
        op_d       = op_q;
        busy_d     = busy_q;
        sda_oe_d   = sda_oe_q;
        load_tx    = 1'b0;
`ifdef I2C_SLAVE_CLK_STRETCH_EN
        stretch_d  = stretch_q;
`endif

        if (start_det || stop_det) begin
            start_d  = start_det;
            stop_d   = stop_det;
            busy_d   = start_det;
            state_d  = start_det ? ST_ADDR : ST_IDLE;
            cnt_d    = '0;
            sda_oe_d = 1'b0;
`ifdef I2C_SLAVE_CLK_STRETCH_EN
            stretch_d = 1'b0;
`endif
        end else begin
            case (state_q)
                ST_ADDR: begin
                    if (scl_rise) begin
                        shift_d = shift_in;
                        cnt_d   = cnt_q + 4'd1;
                        if (cnt_q == LAST_BIT) begin
                            cnt_d = '0;
                            if (shift_in[I2C_DATA_WIDTH-1:1] == I2C_SLAVE_ADDRESS) begin
                                state_d = ST_ADDR_ACK;
                                op_d    = shift_in[0];
                            end else begin
                                state_d = ST_WAIT_STOP;
                            end
                        end
                    end
                end
                // First fall pulls SDA for the ACK slot, the next fall ends it.
                ST_ADDR_ACK: begin
                    if (scl_fall) begin
                        if (!sda_oe_q) begin
                            sda_oe_d = 1'b1;
                        end else begin
                            sda_oe_d = 1'b0;
                            cnt_d    = '0;
                            if (op_q) begin
                                state_d = ST_RD_DATA;
                                load_tx = 1'b1;
                            end else begin
                                state_d = ST_WR_DATA;
                            end
                        end
                    end
                end
                ST_WR_DATA: begin
                    if (scl_rise) begin
                        shift_d = shift_in;
                        cnt_d   = cnt_q + 4'd1;
                        if (cnt_q == LAST_BIT) begin
                            cnt_d = '0;
                            if (rx_valid_q) begin
                                state_d = ST_WAIT_STOP;
                            end else begin
                                rx_data_d  = shift_in;
                                rx_valid_d = 1'b1;
                                state_d    = ST_WR_ACK;
                            end
                        end
                    end
                end
                ST_WR_ACK: begin
                    if (scl_fall) begin
                        if (!sda_oe_q) begin
                            sda_oe_d = 1'b1;
                        end else begin
                            sda_oe_d = 1'b0;
                            cnt_d    = '0;
                            state_d  = ST_WR_DATA;
                        end
                    end
                end
                ST_RD_DATA: begin
                    if (scl_rise) begin
                        cnt_d = cnt_q + 4'd1;
                    end else if (scl_fall) begin
                        if (cnt_q == NUM_BITS) begin
                            sda_oe_d = 1'b0;
                            cnt_d    = '0;
                            state_d  = ST_RD_ACK;
                        end else begin
                            tx_shift_d = {tx_shift_q[I2C_DATA_WIDTH-2:0], 1'b1};
                            sda_oe_d   = ~tx_shift_q[I2C_DATA_WIDTH-2];
                        end
                    end
                end
                // cnt_q == 1 remembers that the master acknowledged the last byte.
                ST_RD_ACK: begin
                    if (scl_rise) begin
                        if (sda_s2_q) begin
                            state_d = ST_WAIT_STOP;
                        end else begin
                            cnt_d = 4'd1;
                        end
                    end else if (scl_fall && cnt_q == 4'd1) begin
                        cnt_d   = '0;
                        state_d = ST_RD_DATA;
                        load_tx = 1'b1;
                    end
                end
                default: begin
                end
            endcase

`ifdef I2C_SLAVE_CLK_STRETCH_EN
            if (stretch_q && tx_valid_i) begin
                load_tx = 1'b1;
            end
`endif

            if (load_tx) begin
                if (tx_valid_i) begin
                    tx_shift_d = tx_data_i;
                    sda_oe_d   = ~tx_data_i[I2C_DATA_WIDTH-1];
                    tx_ready_d = 1'b1;
`ifdef I2C_SLAVE_CLK_STRETCH_EN
                    stretch_d  = 1'b0;
`endif
                end else begin
`ifdef I2C_SLAVE_CLK_STRETCH_EN
                    stretch_d  = 1'b1;
                    sda_oe_d   = 1'b0;
`else
                    tx_shift_d = '1;
                    sda_oe_d   = 1'b0;
`endif
                end
            end
        end

`ifdef I2C_SLAVE_CLK_STRETCH_EN
        // SCL is let go one cycle after the byte is captured, so SDA settles first.
        scl_oe_d = (start_det || stop_det) ? 1'b0 : (stretch_d | stretch_q);
`endif
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            // NOTE: synchronizers reset to the idle bus level (1) so leaving reset fakes no STOP.
            scl_s1_q   <= 1'b1;
            scl_s2_q   <= 1'b1;
            scl_h_q    <= 1'b1;
            sda_s1_q   <= 1'b1;
            sda_s2_q   <= 1'b1;
            sda_h_q    <= 1'b1;
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            shift_q    <= '0;
            tx_shift_q <= '0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            tx_ready_q <= 1'b0;
            start_q    <= 1'b0;
            stop_q     <= 1'b0;
            op_q       <= 1'b0;
            busy_q     <= 1'b0;
            sda_oe_q   <= 1'b0;
`ifdef I2C_SLAVE_CLK_STRETCH_EN
            stretch_q  <= 1'b0;
            scl_oe_q   <= 1'b0;
`endif
        end else begin
            // NOTE: non-blocking everywhere here; all flops update together from pre-edge values.
            scl_s1_q   <= scl_i;
            scl_s2_q   <= scl_s1_q;
            scl_h_q    <= scl_s2_q;
            sda_s1_q   <= sda_i;
            sda_s2_q   <= sda_s1_q;
            sda_h_q    <= sda_s2_q;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            shift_q    <= shift_d;
            tx_shift_q <= tx_shift_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            tx_ready_q <= tx_ready_d;
            start_q    <= start_d;
            stop_q     <= stop_d;
            op_q       <= op_d;
            busy_q     <= busy_d;
            sda_oe_q   <= sda_oe_d;
`ifdef I2C_SLAVE_CLK_STRETCH_EN
            stretch_q  <= stretch_d;
            scl_oe_q   <= scl_oe_d;
`endif
        end
    end

`ifdef I2C_SLAVE_CLK_STRETCH_EN
    assign scl_oe_o = scl_oe_q;
`else
    assign scl_oe_o = 1'b0;
`endif
    assign sda_oe_o   = sda_oe_q;
    assign rx_data_o  = rx_data_q;
    assign rx_valid_o = rx_valid_q;
    assign tx_ready_o = tx_ready_q;
    assign start_o    = start_q;
    assign stop_o     = stop_q;
    assign op_o       = op_q;
    assign busy_o     = busy_q;

endmodule

// File: tb/tb_i2c_slave_target.sv
// Directed bench for i2c_slave_target: a bit-banged master drives a wired-AND SCL/SDA bus.
`timescale 1ns/1ps
module tb_i2c_slave_target;

    localparam int Q           = 5;    // clk_i cycles per quarter SCL period
    localparam int SCL_TIMEOUT = 500;

    logic       clk_i      = 1'b0;
    logic       rst_n_i    = 1'b0;
    logic       m_scl      = 1'b1;
    logic       m_sda      = 1'b1;
    logic       scl_bus, sda_bus;
    logic       scl_oe_o, sda_oe_o;
    logic [7:0] rx_data_o;
    logic       rx_valid_o;
    logic       rx_ready_i = 1'b0;
    logic [7:0] tx_data_i  = 8'h00;
    logic       tx_valid_i = 1'b0;
    logic       tx_ready_o, start_o, stop_o, op_o, busy_o;

    int n_checks = 0;
    int n_errors = 0;
    int n_start = 0, n_stop = 0, n_rxv = 0, n_txr = 0, n_sda_low = 0;
    logic rxv_prev = 1'b0, sda_oe_prev = 1'b0;

    always #5 clk_i = ~clk_i;

    assign scl_bus = m_scl & ~scl_oe_o;
    assign sda_bus = m_sda & ~sda_oe_o;

    i2c_slave_target dut (
        .clk_i      (clk_i),
        .rst_n_i    (rst_n_i),
        .scl_i      (scl_bus),
        .sda_i      (sda_bus),
        .scl_oe_o   (scl_oe_o),
        .sda_oe_o   (sda_oe_o),
        .rx_data_o  (rx_data_o),
        .rx_valid_o (rx_valid_o),
        .rx_ready_i (rx_ready_i),
        .tx_data_i  (tx_data_i),
        .tx_valid_i (tx_valid_i),
        .tx_ready_o (tx_ready_o),
        .start_o    (start_o),
        .stop_o     (stop_o),
        .op_o       (op_o),
        .busy_o     (busy_o)
    );

    // Event counters; sampled mid-cycle so each 1-cycle pulse is seen exactly once.
    always @(negedge clk_i) begin
        if (start_o) n_start++;
        if (stop_o) n_stop++;
        if (tx_ready_o) n_txr++;
        if (rx_valid_o && !rxv_prev) n_rxv++;
        if (sda_oe_o && !sda_oe_prev) n_sda_low++;
        rxv_prev    = rx_valid_o;
        sda_oe_prev = sda_oe_o;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk_i);
    endtask

    task automatic scl_release();
        int waited = 0;
        m_scl = 1'b1;
        do begin
            @(negedge clk_i);
            waited++;
        end while (scl_bus !== 1'b1 && waited < SCL_TIMEOUT);
        if (scl_bus !== 1'b1) check("scl_release_timeout", scl_bus, 1'b1);
    endtask

    task automatic write_bit(input logic b);
        m_sda = b;
        tick(Q);
        scl_release();
        tick(2 * Q);
        m_scl = 1'b0;
        tick(Q);
    endtask

    task automatic read_bit(output logic b);
        m_sda = 1'b1;
        tick(Q);
        scl_release();
        tick(Q);
        b = sda_bus;
        tick(Q);
        m_scl = 1'b0;
        tick(Q);
    endtask

    task automatic write_byte(input logic [7:0] d, output logic ack);
        for (int i = 7; i >= 0; i--) write_bit(d[i]);
        read_bit(ack);
    endtask

    task automatic read_byte(output logic [7:0] d, input logic mack);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            read_bit(b);
            d[i] = b;
        end
        write_bit(mack);
    endtask

    task automatic start_cond();
        m_sda = 1'b1;
        tick(Q);
        scl_release();
        tick(Q);
        m_sda = 1'b0;
        tick(Q);
        m_scl = 1'b0;
        tick(Q);
    endtask

    task automatic stop_cond();
        m_sda = 1'b0;
        tick(Q);
        scl_release();
        tick(Q);
        m_sda = 1'b1;
        tick(2 * Q);
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic       ack;
        logic [7:0] rd;
        logic [7:0] pat;
        int s0, p0, r0, t0, l0, w;

        // Reset state
        tick(3);
        check("rst_scl_oe", scl_oe_o, 1'b0);
        check("rst_sda_oe", sda_oe_o, 1'b0);
        check("rst_rx_data", rx_data_o, 8'h00);
        check("rst_rx_valid", rx_valid_o, 1'b0);
        check("rst_tx_ready", tx_ready_o, 1'b0);
        check("rst_start", start_o, 1'b0);
        check("rst_stop", stop_o, 1'b0);
        check("rst_op", op_o, 1'b0);
        check("rst_busy", busy_o, 1'b0);
        rst_n_i = 1'b1;
        tick(5);
        check("idle_no_stop", n_stop, 0);

        // Write 0xA5 to address 0x22
        rx_ready_i = 1'b1;
        s0 = n_start; p0 = n_stop; r0 = n_rxv;
        start_cond();
        check("wr_busy", busy_o, 1'b1);
        write_byte(8'h44, ack);
        check("wr_addr_ack", ack, 1'b0);
        check("wr_op", op_o, 1'b0);
        write_byte(8'hA5, ack);
        check("wr_data_ack", ack, 1'b0);
        stop_cond();
        check("wr_rx_data", rx_data_o, 8'hA5);
        check("wr_rx_valid_pulses", n_rxv - r0, 1);
        check("wr_start_pulses", n_start - s0, 1);
        check("wr_stop_pulses", n_stop - p0, 1);
        check("wr_busy_after_stop", busy_o, 1'b0);

        // Address mismatch
        l0 = n_sda_low; r0 = n_rxv;
        start_cond();
        check("mm_busy", busy_o, 1'b1);
        write_byte(8'h46, ack);
        check("mm_addr_nack", ack, 1'b1);
        write_byte(8'h12, ack);
        check("mm_data_nack", ack, 1'b1);
        stop_cond();
        check("mm_sda_never_low", n_sda_low - l0, 0);
        check("mm_no_rx_valid", n_rxv - r0, 0);
        check("mm_busy_after_stop", busy_o, 1'b0);

        // Read two bytes from the tx stream
        t0 = n_txr;
        tx_data_i  = 8'h3C;
        tx_valid_i = 1'b1;
        start_cond();
        write_byte(8'h45, ack);
        check("rd_addr_ack", ack, 1'b0);
        check("rd_op", op_o, 1'b1);
        tx_data_i = 8'h81;
        read_byte(rd, 1'b0);
        check("rd_byte0", rd, 8'h3C);
        tx_valid_i = 1'b0;
        read_byte(rd, 1'b1);
        check("rd_byte1", rd, 8'h81);
        stop_cond();
        check("rd_tx_ready_pulses", n_txr - t0, 2);
        check("rd_busy_after_stop", busy_o, 1'b0);

        // Overrun: consumer never ready
        rx_ready_i = 1'b0;
        start_cond();
        write_byte(8'h44, ack);
        check("ov_addr_ack", ack, 1'b0);
        write_byte(8'h11, ack);
        check("ov_byte0_ack", ack, 1'b0);
        check("ov_rx_valid", rx_valid_o, 1'b1);
        write_byte(8'h22, ack);
        check("ov_byte1_nack", ack, 1'b1);
        check("ov_rx_data_held", rx_data_o, 8'h11);
        l0 = n_sda_low;
        write_byte(8'h33, ack);
        check("ov_wait_stop_nack", ack, 1'b1);
        check("ov_wait_stop_sda", n_sda_low - l0, 0);
        check("ov_busy", busy_o, 1'b1);
        stop_cond();
        check("ov_busy_after_stop", busy_o, 1'b0);
        check("ov_rx_data_after_stop", rx_data_o, 8'h11);
        rx_ready_i = 1'b1;
        tick(2);
        check("ov_rx_valid_drained", rx_valid_o, 1'b0);

        // Repeated START: write then read
        s0 = n_start;
        tx_data_i  = 8'h99;
        tx_valid_i = 1'b1;
        start_cond();
        write_byte(8'h44, ack);
        check("sr_addr_w_ack", ack, 1'b0);
        write_byte(8'h07, ack);
        check("sr_data_ack", ack, 1'b0);
        check("sr_rx_data", rx_data_o, 8'h07);
        check("sr_op_write", op_o, 1'b0);
        start_cond();
        check("sr_busy", busy_o, 1'b1);
        write_byte(8'h45, ack);
        check("sr_addr_r_ack", ack, 1'b0);
        check("sr_op_read", op_o, 1'b1);
        tx_valid_i = 1'b0;
        read_byte(rd, 1'b1);
        check("sr_rd_byte", rd, 8'h99);
        check("sr_busy_held", busy_o, 1'b1);
        stop_cond();
        check("sr_start_pulses", n_start - s0, 2);
        check("sr_busy_after_stop", busy_o, 1'b0);

        // Read with no tx data available
        t0 = n_txr;
        tx_valid_i = 1'b0;
        start_cond();
        write_byte(8'h45, ack);
        check("nd_addr_ack", ack, 1'b0);
`ifdef I2C_SLAVE_CLK_STRETCH_EN
        fork
            read_byte(rd, 1'b1);
            begin
                tick(4 * Q);
                check("nd_stretch_scl_oe", scl_oe_o, 1'b1);
                check("nd_stretch_scl_bus", scl_bus, 1'b0);
                tx_data_i  = 8'h5A;
                tx_valid_i = 1'b1;
                w = 0;
                while (!tx_ready_o && w < 50) begin
                    tick(1);
                    w++;
                end
                check("nd_stretch_tx_ready", tx_ready_o, 1'b1);
                tx_valid_i = 1'b0;
            end
        join
        check("nd_rd_byte", rd, 8'h5A);
        check("nd_tx_ready_pulses", n_txr - t0, 1);
`else
        check("nd_no_stretch_scl_oe", scl_oe_o, 1'b0);
        read_byte(rd, 1'b1);
        check("nd_rd_byte", rd, 8'hFF);
        check("nd_tx_ready_pulses", n_txr - t0, 0);
`endif
        stop_cond();
        check("nd_busy_after_stop", busy_o, 1'b0);

        // Reset asserted while the target is pulling SDA for an ACK
        rx_ready_i = 1'b0;
        start_cond();
        write_byte(8'h44, ack);
        check("rst_seq_addr_ack", ack, 1'b0);
        pat = 8'h6C;
        for (int i = 7; i >= 0; i--) write_bit(pat[i]);
        m_sda = 1'b1;
        tick(Q);
        check("rst_seq_sda_oe_before", sda_oe_o, 1'b1);
        check("rst_seq_rx_valid_before", rx_valid_o, 1'b1);
        #2 rst_n_i = 1'b0;
        #1;
        check("rst_async_sda_oe", sda_oe_o, 1'b0);
        check("rst_async_scl_oe", scl_oe_o, 1'b0);
        check("rst_async_rx_valid", rx_valid_o, 1'b0);
        check("rst_async_rx_data", rx_data_o, 8'h00);
        check("rst_async_busy", busy_o, 1'b0);
        m_scl = 1'b1;
        m_sda = 1'b1;
        tick(3);
        rst_n_i = 1'b1;
        rx_ready_i = 1'b1;
        tick(5);

        // Normal write after the reset
        start_cond();
        write_byte(8'h44, ack);
        check("post_rst_addr_ack", ack, 1'b0);
        write_byte(8'hC3, ack);
        check("post_rst_data_ack", ack, 1'b0);
        stop_cond();
        check("post_rst_rx_data", rx_data_o, 8'hC3);
        check("post_rst_busy", busy_o, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
